// File: rtl/debounce_scan_ctrl.sv
// Shared-counter debouncer: a round-robin scanner walks N synchronized inputs and
// tracks one changed channel at a time with a single stability counter.
module debounce_scan_ctrl #(
    parameter int N      = 4,
    parameter int CH_W   = 2,
    parameter int STABLE = 100,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    signal_in,
    output logic [N-1:0]    level_out,
    output logic [N-1:0]    pulse_out,
    output logic            busy,
    output logic [CH_W-1:0] active_ch
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        COMMIT
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  ptr;
    logic             cand;
    logic [N-1:0]     sync_meta;
    logic [N-1:0]     sync;
    logic [CH_W-1:0]  next_ptr;

    // Two-flop synchronizer; only the second stage is ever looked at.
    // NOTE: every flop, synchronizer included, clears on the asynchronous reset so the
    // first post-reset scan starts from a known all-zero view of the inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= signal_in;
            sync      <= sync_meta;
        end
    end

    assign next_ptr  = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
    assign active_ch = ptr;

    // NOTE: sequential state uses non-blocking assignments so every branch below reads
    // the pre-edge values of state, cnt, ptr and level_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            cand      <= 1'b0;
            level_out <= '0;
            pulse_out <= '0;
            busy      <= 1'b0;
        end else begin
            pulse_out <= '0;
            case (state)
                IDLE: begin
                    if (sync[ptr] != level_out[ptr]) begin
                        cand  <= sync[ptr];
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                        state <= TRACK;
                    end else begin
                        ptr <= next_ptr;
                    end
                end
                TRACK: begin
                    if (sync[ptr] != cand) begin
                        // Glitch: give up and move on so a chattering input cannot hog the counter.
                        cnt   <= '0;
                        ptr   <= next_ptr;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == STABLE_CNT) begin
                        // Pulse is registered together with the COMMIT state, so it lasts exactly that cycle.
                        pulse_out[ptr] <= cand;
                        state          <= COMMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    level_out[ptr] <= cand;
                    cnt            <= '0;
                    ptr            <= next_ptr;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed scenarios plus random input churn, all checked
// cycle by cycle against a time-stamp based reference model of the scanner.
module tb_debounce_scan_ctrl;

    localparam int N      = 4;
    localparam int CH_W   = 2;
    localparam int STABLE = 4;
    localparam int CNT_W  = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    signal_in;
    logic [N-1:0]    level_out;
    logic [N-1:0]    pulse_out;
    logic            busy;
    logic [CH_W-1:0] active_ch;

    debounce_scan_ctrl #(
        .N(N), .CH_W(CH_W), .STABLE(STABLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .signal_in(signal_in),
        .level_out(level_out),
        .pulse_out(pulse_out),
        .busy(busy),
        .active_ch(active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: scan position, whether a channel is under watch, since which edge,
    // and the committed levels. Inputs reach the scanner two edges after they are applied.
    int           m_ptr;
    bit           m_trk;
    logic         m_cand;
    int           m_start;
    int           m_cyc;
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_hist[$];
    logic [N-1:0] exp_pulse;

    logic [N-1:0] cur;
    int           gcyc = 0;
    int           pc[N];
    int           pcyc[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_trk   = 0;
        m_cand  = 1'b0;
        m_start = 0;
        m_cyc   = 0;
        m_lvl   = '0;
        m_hist.delete();
        exp_pulse = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] v);
        logic [N-1:0] s;
        s = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : '0;
        if (!m_trk) begin
            if (s[m_ptr] != m_lvl[m_ptr]) begin
                m_trk   = 1;
                m_cand  = s[m_ptr];
                m_start = m_cyc;
            end else begin
                m_ptr = (m_ptr + 1) % N;
            end
        end else if (m_cyc == m_start + STABLE + 1) begin
            m_lvl[m_ptr] = m_cand;
            m_trk        = 0;
            m_ptr        = (m_ptr + 1) % N;
        end else if (s[m_ptr] != m_cand) begin
            m_trk = 0;
            m_ptr = (m_ptr + 1) % N;
        end
        exp_pulse = '0;
        if (m_trk && m_cyc == m_start + STABLE && m_cand)
            exp_pulse[m_ptr] = 1'b1;
        m_hist.push_back(v);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        m_cyc++;
    endtask

    // Called just after a falling edge: apply v, clock once, compare, return at the next falling edge.
    task automatic step(input logic [N-1:0] v);
        cur       = v;
        signal_in = v;
        @(posedge clk);
        gcyc++;
        model_edge(v);
        #1;
        check("level_out", 32'(level_out), 32'(m_lvl));
        check("pulse_out", 32'(pulse_out), 32'(exp_pulse));
        check("busy",      32'(busy),      32'(m_trk));
        check("active_ch", 32'(active_ch), 32'(m_ptr));
        for (int i = 0; i < N; i++) begin
            if (pulse_out[i]) begin
                pc[i]++;
                pcyc[i] = gcyc;
            end
        end
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            pc[i]   = 0;
            pcyc[i] = -1;
        end
    endtask

    task automatic align(input int tgt);
        int k;
        k = 0;
        while (int'(active_ch) != tgt && k < 2 * N) begin
            step(cur);
            k++;
        end
        check("align", 32'(active_ch), 32'(tgt));
    endtask

    initial begin
        int t0;
        int k;
        logic [N-1:0] bounce[6];
        logic         t;

        reset     = 1'b1;
        signal_in = '0;
        cur       = '0;
        clear_counts();
        model_reset();
        #7;
        check("rst_level",  32'(level_out), 32'h0);
        check("rst_pulse",  32'(pulse_out), 32'h0);
        check("rst_busy",   32'(busy),      32'h0);
        check("rst_active", 32'(active_ch), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Clean press on ch0 with the scanner arriving exactly at detection time.
        align(N - 2);
        clear_counts();
        t0 = gcyc + 1;
        hold(4'b0001, 14);
        check("press_pc0",    32'(pc[0]), 32'd1);
        check("press_others", 32'(pc[1] + pc[2] + pc[3]), 32'd0);
        check("press_lat",    32'(pcyc[0] - t0), 32'(STABLE + 2));

        // Release: level drops, no pulse.
        clear_counts();
        hold(4'b0000, 14);
        check("release_pc",  32'(pc[0] + pc[1] + pc[2] + pc[3]), 32'd0);
        check("release_lvl", 32'(level_out[0]), 32'd0);

        // Bounce on ch0 then steady high.
        bounce = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        clear_counts();
        for (int i = 0; i < 6; i++) step(bounce[i]);
        hold(4'b0001, 20);
        check("bounce_pc0",    32'(pc[0]), 32'd1);
        check("bounce_others", 32'(pc[1] + pc[2] + pc[3]), 32'd0);
        hold(4'b0000, 14);

        // Simultaneous press on ch1 and ch2, scanner positioned to reach ch1 first.
        align(N - 1);
        clear_counts();
        hold(4'b0110, 30);
        check("simul_pc1",   32'(pc[1]), 32'd1);
        check("simul_pc2",   32'(pc[2]), 32'd1);
        check("simul_order", 32'(pcyc[1] < pcyc[2]), 32'd1);
        check("simul_gap",   32'(pcyc[2] - pcyc[1] >= STABLE + 2), 32'd1);

        // Chatter on ch0 must not starve ch3.
        clear_counts();
        t0 = gcyc + 1;
        t  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0 && i > 0) t = ~t;
            step({3'b111, t});
        end
        check("chatter_pc0", 32'(pc[0]), 32'd0);
        check("chatter_pc3", 32'(pc[3]), 32'd1);
        check("chatter_lat", 32'(pcyc[3] - t0 <= 2 * (STABLE + 2) + N + 2), 32'd1);

        // Asynchronous reset in the middle of a track.
        hold(4'b0000, 30);
        k = 0;
        cur = 4'b0100;
        while (!busy && k < 12) begin
            step(cur);
            k++;
        end
        check("busy_seen", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_level",  32'(level_out), 32'h0);
        check("arst_pulse",  32'(pulse_out), 32'h0);
        check("arst_busy",   32'(busy),      32'h0);
        check("arst_active", 32'(active_ch), 32'h0);
        #2 reset = 1'b0;
        model_reset();
        clear_counts();
        hold(4'b0100, 16);
        check("arst_redetect", 32'(pc[2]), 32'd1);

        // Random churn: each bit occasionally flips, so both glitches and stable runs occur.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] v;
            v = cur;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) v[b] = ~v[b];
            step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
